// File: rtl/dcache_pkg.sv
// Shared types and field positions for the 16-set, 2-way data cache sequencer.
package dcache_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned INDEX_W   = 4;
    localparam int unsigned OFFSET_W  = 5;
    localparam int unsigned LINE_W    = 256;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned TAG_W     = 25;
    localparam int unsigned ATAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned WSEL_W    = 3;

    // Status bits in the SRAM tag word; the address tag sits below them.
    localparam int unsigned VALID_BIT = 24;
    localparam int unsigned DIRTY_BIT = 23;

    localparam int unsigned INDEX_LSB = OFFSET_W;
    localparam int unsigned INDEX_MSB = OFFSET_W + INDEX_W - 1;
    localparam int unsigned TAG_LSB   = OFFSET_W + INDEX_W;
    localparam int unsigned WSEL_LSB  = 2;
    localparam int unsigned WSEL_MSB  = WSEL_LSB + WSEL_W - 1;

    typedef enum logic [1:0] {
        StIdle,
        StWriteback,
        StAllocate,
        StRefill
    } state_e;

endpackage

// File: rtl/dcache_word_merge.sv
// Line/word helper: overlays one 32-bit word into a cache line and extracts the
// selected word from the unmodified line.
module dcache_word_merge
    import dcache_pkg::*;
(
    input  logic [LINE_W-1:0] i_line,
    input  logic [WORD_W-1:0] i_word,
    input  logic [WSEL_W-1:0] i_sel,
    output logic [LINE_W-1:0] o_line,
    output logic [WORD_W-1:0] o_word
);

    logic [7:0] w_base;

    assign w_base = {i_sel, 5'b0};

    always_comb begin
        o_line = i_line;
        o_line[w_base +: WORD_W] = i_word;
    end

    assign o_word = i_line[w_base +: WORD_W];

endmodule

// File: rtl/dcache_ctrl.sv
// Write-back/write-allocate sequencer between the CPU port, the dcache SRAM and
// off-chip memory. Hits complete in IDLE; misses walk WRITEBACK/ALLOCATE/REFILL.
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_write_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [WORD_W-1:0] cpu_data_i,
    output logic [WORD_W-1:0] cpu_data_o,
    output logic              cpu_stall_o,
    output logic              sram_enable_o,
    output logic              sram_write_o,
    output logic [INDEX_W-1:0] sram_addr_o,
    output logic [TAG_W-1:0]  sram_tag_o,
    output logic [LINE_W-1:0] sram_data_o,
    input  logic [TAG_W-1:0]  sram_tag_i,
    input  logic [LINE_W-1:0] sram_data_i,
    input  logic              sram_hit_i,
    output logic              mem_req_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);

    state_e              r_state;
    logic [ATAG_W-1:0]   r_victim_tag;
    logic [LINE_W-1:0]   r_victim_line;
    logic [LINE_W-1:0]   r_refill_line;

    logic [INDEX_W-1:0]  w_index;
    logic [ATAG_W-1:0]   w_tag;
    logic [WSEL_W-1:0]   w_wsel;
    logic                w_idle;
    logic                w_refill;
    logic                w_victim_dirty;
    logic [LINE_W-1:0]   w_merge_src;
    logic [LINE_W-1:0]   w_merged;
    logic [1:0]          w_unused_byte_sel;

    assign w_index           = cpu_addr_i[INDEX_MSB:INDEX_LSB];
    assign w_tag             = cpu_addr_i[ADDR_W-1:TAG_LSB];
    assign w_wsel            = cpu_addr_i[WSEL_MSB:WSEL_LSB];
    assign w_unused_byte_sel = cpu_addr_i[1:0];
    assign w_idle            = (r_state == StIdle);
    assign w_refill          = (r_state == StRefill);
    assign w_victim_dirty    = sram_tag_i[VALID_BIT] & sram_tag_i[DIRTY_BIT];

    // One merger serves both write paths; in IDLE it also feeds the load word.
    assign w_merge_src = w_idle ? sram_data_i : r_refill_line;

    dcache_word_merge u_merge (
        .i_line (w_merge_src),
        .i_word (cpu_data_i),
        .i_sel  (w_wsel),
        .o_line (w_merged),
        .o_word (cpu_data_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= StIdle;
            r_victim_tag  <= '0;
            r_victim_line <= '0;
            r_refill_line <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (cpu_req_i && !sram_hit_i) begin
                        r_victim_tag  <= sram_tag_i[ATAG_W-1:0];
                        r_victim_line <= sram_data_i;
                        r_state       <= w_victim_dirty ? StWriteback : StAllocate;
                    end
                end
                StWriteback: begin
                    if (mem_ack_i) r_state <= StAllocate;
                end
                StAllocate: begin
                    if (mem_ack_i) begin
                        r_refill_line <= mem_data_i;
                        r_state       <= StRefill;
                    end
                end
                StRefill: r_state <= StIdle;
                default:  r_state <= StIdle;
            endcase
        end
    end

    assign cpu_stall_o   = cpu_req_i & ~(w_idle & sram_hit_i);
    assign sram_enable_o = cpu_req_i | ~w_idle;
    assign sram_write_o  = w_refill | (w_idle & cpu_req_i & cpu_write_i & sram_hit_i);
    assign sram_addr_o   = w_index;
    // Dirty bit tracks the access type: stores dirty the line, load refills stay clean.
    assign sram_tag_o    = {1'b1, cpu_write_i, w_tag};
    assign sram_data_o   = (w_refill && !cpu_write_i) ? r_refill_line : w_merged;

    assign mem_req_o   = (r_state == StWriteback) | (r_state == StAllocate);
    assign mem_write_o = (r_state == StWriteback);
    assign mem_addr_o  = mem_write_o ? {r_victim_tag, w_index, {OFFSET_W{1'b0}}}
                                     : {cpu_addr_i[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    assign mem_data_o  = r_victim_line;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: behavioural 2-way LRU SRAM, latency-programmable memory
// with a transaction scoreboard, and a flat reference memory for load data.
`timescale 1ns/1ps
module tb_dcache_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cpu_req_i, cpu_write_i;
    logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
    logic         cpu_stall_o, sram_enable_o, sram_write_o;
    logic [3:0]   sram_addr_o;
    logic [24:0]  sram_tag_o, sram_tag_i;
    logic [255:0] sram_data_o, sram_data_i;
    logic         sram_hit_i;
    logic         mem_req_o, mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o, mem_data_i;
    logic         mem_ack_i, mem_ack_r, spur_ack;

    assign mem_ack_i = mem_ack_r | spur_ack;

    dcache_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_req_i(cpu_req_i), .cpu_write_i(cpu_write_i), .cpu_addr_i(cpu_addr_i),
        .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
        .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o), .sram_addr_o(sram_addr_o),
        .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o), .sram_tag_i(sram_tag_i),
        .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
        .mem_req_o(mem_req_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Initial memory image; line 0x40 carries the 0xDEAD_BEEF marker in word 2.
    function automatic logic [31:0] default_word(input logic [31:0] a);
        if (a[31:5] == 27'd2) return (a[4:2] == 3'd2) ? 32'hDEAD_BEEF : 32'h0;
        return {a[31:2], 2'b01} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [255:0] default_line(input int i);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = default_word({18'd0, i[8:0], k[2:0], 2'b00});
        return l;
    endfunction

    // Reference: flat word memory, i.e. what a transparent cache must return.
    logic [31:0] ref_mem [4096];

    function automatic logic [255:0] ref_line(input logic [31:0] a);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = ref_mem[{a[13:5], k[2:0]}];
        return l;
    endfunction

    // SRAM model: 16 sets x 2 ways, way chosen by hit else LRU.
    logic         s_init;
    logic [24:0]  s_tag  [16][2];
    logic [255:0] s_data [16][2];
    logic         s_lru  [16];
    logic         s_hit0, s_hit1, s_way;

    always_comb begin
        s_hit0      = s_tag[sram_addr_o][0][24] && (s_tag[sram_addr_o][0][22:0] == sram_tag_o[22:0]);
        s_hit1      = s_tag[sram_addr_o][1][24] && (s_tag[sram_addr_o][1][22:0] == sram_tag_o[22:0]);
        sram_hit_i  = s_hit0 | s_hit1;
        s_way       = s_hit0 ? 1'b0 : (s_hit1 ? 1'b1 : s_lru[sram_addr_o]);
        sram_tag_i  = s_tag[sram_addr_o][s_way];
        sram_data_i = s_data[sram_addr_o][s_way];
    end

    always @(posedge clk_i) begin
        if (s_init) begin
            for (int s = 0; s < 16; s++) begin
                // Set 7 starts invalid but with the dirty bit set.
                s_tag[s][0]  <= (s == 7) ? 25'h080_0000 : 25'h0;
                s_tag[s][1]  <= (s == 7) ? 25'h080_0000 : 25'h0;
                s_data[s][0] <= '0;
                s_data[s][1] <= '0;
                s_lru[s]     <= 1'b0;
            end
        end else if (sram_enable_o && sram_write_o) begin
            s_tag[sram_addr_o][s_way]  <= sram_tag_o;
            s_data[sram_addr_o][s_way] <= sram_data_o;
            s_lru[sram_addr_o]         <= ~s_way;
        end else if (cpu_req_i && sram_hit_i && !cpu_stall_o) begin
            s_lru[sram_addr_o] <= ~s_way;
        end
    end

    // Memory model and scoreboard of expected line transactions.
    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } txn_t;

    txn_t         exp_q[$];
    logic [255:0] bmem [512];
    int unsigned  ack_delay = 1;
    int unsigned  m_cnt;
    logic         m_fire;

    task automatic push_txn(input logic wr, input logic [31:0] addr, input logic [255:0] data);
        txn_t t;
        t.wr = wr; t.addr = addr; t.data = data;
        exp_q.push_back(t);
    endtask

    task automatic sb_pop(input logic wr, input logic [31:0] addr, input logic [255:0] data);
        txn_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL mem_txn unexpected: got wr=%0b addr=%h, expected none", wr, addr);
        end else begin
            e = exp_q.pop_front();
            if (wr !== e.wr || addr !== e.addr || (wr && data !== e.data)) begin
                errors++;
                $display("FAIL mem_txn: got wr=%0b addr=%h data=%h expected wr=%0b addr=%h data=%h",
                         wr, addr, data, e.wr, e.addr, e.data);
            end
        end
    endtask

    always_comb m_fire = mem_req_o && !mem_ack_r && (m_cnt + 1 >= ack_delay);

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_ack_r <= 1'b0;
            m_cnt     <= 0;
        end else begin
            mem_ack_r <= 1'b0;
            if (m_fire) begin
                sb_pop(mem_write_o, mem_addr_o, mem_data_o);
                mem_ack_r <= 1'b1;
                m_cnt     <= 0;
                if (!mem_write_o) mem_data_i <= bmem[mem_addr_o[13:5]];
            end else if (mem_req_o && !mem_ack_r) begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    always @(posedge clk_i) begin
        if (s_init) begin
            for (int i = 0; i < 512; i++) bmem[i] <= default_line(i);
        end else if (!rst_i && m_fire && mem_write_o) begin
            bmem[mem_addr_o[13:5]] <= mem_data_o;
        end
    end

    // One CPU access, held until the stall drops; entered and left at posedge+1.
    int req_cycles, unstable;

    task automatic do_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic exp_hit, input logic exp_dirty, input string name);
        logic [31:0]  exp_rd, first_addr, wt;
        logic [255:0] first_data, wd;
        int           lat, found;
        logic         done;
        cpu_req_i = 1'b1; cpu_write_i = wr; cpu_addr_i = addr; cpu_data_i = wdata;
        exp_rd = ref_mem[addr[13:2]];
        if (wr) ref_mem[addr[13:2]] = wdata;
        lat = 0; done = 1'b0; req_cycles = 0; unstable = 0;
        first_addr = '0; first_data = '0;
        while (!done && lat < 200) begin
            @(negedge clk_i);
            if (mem_req_o) begin
                if (req_cycles == 0) begin
                    first_addr = mem_addr_o; first_data = mem_data_o;
                end else if (mem_addr_o !== first_addr || mem_data_o !== first_data || !cpu_stall_o) begin
                    unstable++;
                end
                req_cycles++;
            end
            if (!cpu_stall_o) begin
                done = 1'b1;
                if (!wr) check32({name, " load data"}, cpu_data_o, exp_rd);
            end else begin
                lat++;
            end
            @(posedge clk_i); #1;
        end
        cpu_req_i = 1'b0;
        check32({name, " completed"}, 32'(done), 32'd1);
        check32({name, " zero-latency hit"}, 32'(lat == 0), 32'(exp_hit));
        check32({name, " mem txns drained"}, exp_q.size(), 32'd0);
        found = 0; wt = '0; wd = '0;
        for (int w = 0; w < 2; w++) begin
            if (s_tag[addr[8:5]][w][24] && s_tag[addr[8:5]][w][22:0] == addr[31:9]) begin
                found = 1; wt = 32'(s_tag[addr[8:5]][w]); wd = s_data[addr[8:5]][w];
            end
        end
        check32({name, " line present"}, found, 32'd1);
        check32({name, " sram tag"}, wt, {7'd0, 1'b1, exp_dirty, addr[31:9]});
        check32({name, " sram word"}, wd[{addr[4:2], 5'b0} +: 32], ref_mem[addr[13:2]]);
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        hit;
        logic        wb;
        logic [31:0] wb_addr;
        logic        dirty;
    } vec_t;

    vec_t vt[15];
    int   bad;

    initial begin
        vt[0]  = '{1'b0, 32'h040,  32'h0,         1'b0, 1'b0, 32'h0,   1'b0};
        vt[1]  = '{1'b1, 32'h048,  32'h1234_5678, 1'b1, 1'b0, 32'h0,   1'b1};
        vt[2]  = '{1'b0, 32'h048,  32'h0,         1'b1, 1'b0, 32'h0,   1'b1};
        vt[3]  = '{1'b0, 32'h240,  32'h0,         1'b0, 1'b0, 32'h0,   1'b0};
        vt[4]  = '{1'b0, 32'h440,  32'h0,         1'b0, 1'b1, 32'h040, 1'b0};
        vt[5]  = '{1'b0, 32'h048,  32'h0,         1'b0, 1'b0, 32'h0,   1'b0};
        vt[6]  = '{1'b1, 32'h25C,  32'hCAFE_F00D, 1'b0, 1'b0, 32'h0,   1'b1};
        vt[7]  = '{1'b0, 32'h25C,  32'h0,         1'b1, 1'b0, 32'h0,   1'b1};
        vt[8]  = '{1'b0, 32'h444,  32'h0,         1'b0, 1'b0, 32'h0,   1'b0};
        vt[9]  = '{1'b0, 32'h840,  32'h0,         1'b0, 1'b1, 32'h240, 1'b0};
        vt[10] = '{1'b0, 32'h25C,  32'h0,         1'b0, 1'b0, 32'h0,   1'b0};
        vt[11] = '{1'b1, 32'h1004, 32'hA5A5_5A5A, 1'b0, 1'b0, 32'h0,   1'b1};
        vt[12] = '{1'b0, 32'h1004, 32'h0,         1'b1, 1'b0, 32'h0,   1'b1};
        vt[13] = '{1'b0, 32'h101C, 32'h0,         1'b1, 1'b0, 32'h0,   1'b1};
        vt[14] = '{1'b0, 32'h0E4,  32'h0,         1'b0, 1'b0, 32'h0,   1'b0};

        for (int i = 0; i < 4096; i++) ref_mem[i] = default_word({18'd0, i[11:0], 2'b00});

        rst_i = 1'b1; s_init = 1'b1; spur_ack = 1'b0;
        cpu_req_i = 1'b0; cpu_write_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check32("reset mem_req", 32'(mem_req_o), 32'd0);
        check32("reset mem_write", 32'(mem_write_o), 32'd0);
        check32("reset sram_write", 32'(sram_write_o), 32'd0);
        check32("reset stall", 32'(cpu_stall_o), 32'd0);
        check32("reset sram_enable", 32'(sram_enable_o), 32'd0);
        check32("reset victim line", 32'(mem_data_o != 256'd0), 32'd0);
        s_init = 1'b0;
        @(negedge clk_i) rst_i = 1'b0;
        @(posedge clk_i); #1;

        // Idle with no request, including a stray ack, must stay quiet.
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            spur_ack = (c == 1);
            @(negedge clk_i);
            if (mem_req_o || sram_write_o || cpu_stall_o || sram_enable_o) bad++;
            @(posedge clk_i); #1;
        end
        spur_ack = 1'b0;
        check32("idle quiet with stray ack", bad, 32'd0);

        for (int i = 0; i < 15; i++) begin
            if (!vt[i].hit) begin
                if (vt[i].wb) push_txn(1'b1, vt[i].wb_addr, ref_line(vt[i].wb_addr));
                push_txn(1'b0, {vt[i].addr[31:5], 5'b0}, '0);
            end
            do_access(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].hit, vt[i].dirty,
                      $sformatf("vec%0d", i));
        end

        // Slow memory: request and address must hold until the ack.
        ack_delay = 10;
        push_txn(1'b0, 32'h3000, '0);
        do_access(1'b0, 32'h3000, 32'h0, 1'b0, 1'b0, "delay10");
        check32("delay10 req cycles", req_cycles, ack_delay + 1);
        check32("delay10 req stable", unstable, 32'd0);
        ack_delay = 1;

        // Make both ways of set 5 dirty, then reset in the middle of a write-back.
        push_txn(1'b0, 32'h0A0, '0);
        do_access(1'b1, 32'h0A0, 32'h1111_2222, 1'b0, 1'b1, "set5 store a");
        push_txn(1'b0, 32'h2A0, '0);
        do_access(1'b1, 32'h2A4, 32'h3333_4444, 1'b0, 1'b1, "set5 store b");
        ack_delay = 20;
        cpu_req_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h4A0;
        for (int n = 0; n < 20 && !(mem_req_o && mem_write_o); n++) @(negedge clk_i);
        check32("rst_wb writeback entered", 32'(mem_req_o && mem_write_o), 32'd1);
        check32("rst_wb victim addr", mem_addr_o, 32'h0A0);
        repeat (3) @(posedge clk_i);
        #2 rst_i = 1'b1; cpu_req_i = 1'b0;
        #1;
        check32("rst_wb mem_req dropped", 32'(mem_req_o), 32'd0);
        check32("rst_wb mem_write dropped", 32'(mem_write_o), 32'd0);
        check32("rst_wb stall", 32'(cpu_stall_o), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk_i);
        #3 rst_i = 1'b0;
        ack_delay = 1;
        @(posedge clk_i); #1;
        push_txn(1'b1, 32'h0A0, ref_line(32'h0A0));
        push_txn(1'b0, 32'h4A0, '0);
        do_access(1'b0, 32'h4A0, 32'h0, 1'b0, 1'b0, "rst_retry");

        check32("scoreboard empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
